// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock with registered quotient/remainder and a done pulse.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating quotient, remainder takes dividend sign).
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0] state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, dsr, a_mag, b_mag, q_res, r_res, r_sel;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic fit, dz, load, step, busy_d, done_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sa, sb;
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign r_sel = dz ? dvd : rem;
  assign q_res = dz ? '1 : ((sa ^ sb) ? -dvd : dvd);
  assign r_res = sa ? -r_sel : r_sel;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign r_sel = dz ? dvd : rem;
  assign q_res = dz ? '1 : dvd;
  assign r_res = r_sel;
`endif
  // A fitting difference is below the divisor, so both top bits are clear exactly when the trial succeeds.
  assign rem_sh = {rem, dvd[WIDTH-1]};
  assign diff = {1'b0, rem_sh} - {2'b00, dsr};
  assign fit = diff[WIDTH+1:WIDTH] == 2'b00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = (state == IDLE) ? (start ? ((divisor == '0) ? DONE : RUN) : IDLE) :
          (state == RUN) ? ((cnt == CW'(WIDTH - 1)) ? DONE : RUN) : IDLE;
  always_comb begin
    load = (state == IDLE) && start;
    step = state == RUN;
    busy_d = nxt == RUN;
    done_d = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      dvd <= '0;
      dsr <= '0;
      dz <= 1'b0;
      cnt <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa <= 1'b0;
      sb <= 1'b0;
`endif
    end else if (load) begin
      rem <= '0;
      dvd <= a_mag;
      dsr <= b_mag;
      dz <= divisor == '0;
      cnt <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa <= dividend[WIDTH-1];
      sb <= divisor[WIDTH-1];
`endif
    end else if (step) begin
      rem <= fit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      dvd <= {dvd[WIDTH-2:0], fit};
      cnt <= cnt + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (done_d) begin
        quotient <= q_res;
        remainder <= r_res;
        div_by_zero <= dz;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider (WIDTH=4); signed vectors when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;
  logic clk, rst_n, start, busy, done, div_by_zero;
  logic [3:0] dividend, divisor, quotient, remainder;
  int tests = 0, fails = 0;

  seq_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one operation and returns edges from the accepting edge to the done pulse and busy cycles seen.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat, output int nb);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dividend = 4'hx;
    divisor = 4'hx;
    lat = 0;
    nb = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er, input logic ez, input int elat);
    int lat, nb;
    run_op(a, b, lat, nb);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, div_by_zero, ez);
  endtask

  initial begin
    int lat, nb, idx, score;
    logic [3:0] ops_a [3] = '{4'd15, 4'd7, 4'd0};
    logic [3:0] ops_b [3] = '{4'd1, 4'd2, 4'd5};
    logic [3:0] exp_q [3] = '{4'd15, 4'd3, 4'd0};
    logic [3:0] exp_r [3] = '{4'd0, 4'd1, 4'd0};
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_by_zero, 0);
    @(negedge clk) rst_n = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
    do_op("s_m7_2", 4'b1001, 4'd2, 4'hD, 4'hF, 1'b0, 5);
    do_op("s_7_m2", 4'd7, 4'b1110, 4'hD, 4'd1, 1'b0, 5);
    do_op("s_m8_m1", 4'b1000, 4'hF, 4'h8, 4'd0, 1'b0, 5);
    do_op("s_m5_0", 4'b1011, 4'd0, 4'hF, 4'hB, 1'b1, 1);
    do_op("s_6_3", 4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 5);
`else
    run_op(4'd13, 4'd3, lat, nb);
    check("u13_3_lat", lat, 5);
    check("u13_3_busy", nb, 4);
    check("u13_3_q", quotient, 4);
    check("u13_3_r", remainder, 1);
    check("u13_3_dz", div_by_zero, 0);
    do_op("dz9_0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1);
    @(negedge clk);
    dividend = 4'd14;
    divisor = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("mid_busy_pre", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_q", quotient, 0);
    check("mid_r", remainder, 0);
    check("mid_dz", div_by_zero, 0);
    @(negedge clk) rst_n = 1'b1;
    do_op("u14_3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 5);
    do_op("u9_9", 4'd9, 4'd9, 4'd1, 4'd0, 1'b0, 5);
    @(negedge clk);
    dividend = ops_a[0];
    divisor = ops_b[0];
    start = 1'b1;
    idx = 0;
    for (int e = 0; e < 18; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (idx < 3) begin
          check("b2b_edge", e, 5 + 6 * idx);
          check("b2b_q", quotient, exp_q[idx]);
          check("b2b_r", remainder, exp_r[idx]);
        end
        idx++;
        if (idx < 3) begin
          dividend = ops_a[idx];
          divisor = ops_b[idx];
        end
      end
    end
    start = 1'b0;
    check("b2b_dones", idx, 3);
    score = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++) begin
        run_op(4'(a), 4'(b), lat, nb);
        if (lat == 5 && int'(quotient) * b + int'(remainder) == a && int'(remainder) < b) score++;
      end
    $display("[TB] exhaustive score %0d/240", score);
    check("exh_score", score, 240);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
